// File: rtl/alu_pkg.sv
// alu_pkg: shared request codes, ALU op encodings, controller states and decode record.
package alu_pkg;
   localparam logic [2:0] FUNC_AND  = 3'd0;
   localparam logic [2:0] FUNC_OR   = 3'd1;
   localparam logic [2:0] FUNC_ADD  = 3'd2;
   localparam logic [2:0] FUNC_SUB  = 3'd3;
   localparam logic [2:0] FUNC_SLT  = 3'd4;
   localparam logic [2:0] FUNC_SLTU = 3'd5;
   localparam logic [2:0] FUNC_NOR  = 3'd6;
   localparam logic [2:0] FUNC_NAND = 3'd7;
   localparam logic [1:0] ALU_OP_AND  = 2'b00;
   localparam logic [1:0] ALU_OP_OR   = 2'b01;
   localparam logic [1:0] ALU_OP_ADD  = 2'b10;
   localparam logic [1:0] ALU_OP_LESS = 2'b11;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_SLT2 = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;
   typedef struct packed {
      logic       a_inv;
      logic       b_inv;
      logic       cin;
      logic [1:0] op;
      logic       is_slt;
      logic       is_signed;
      logic       is_arith;
   } dec_t;
endpackage

// File: rtl/alu32.sv
// alu32: combinational 32-bit ALU with operand inversion, carry-in and a less input on bit 0.
module alu32 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             less,
   input  logic             A_invert,
   input  logic             B_invert,
   input  logic             cin,
   input  logic [1:0]       operation,
   output logic [WIDTH-1:0] result,
   output logic             cout
);
   logic [WIDTH-1:0] a, b;
   logic [WIDTH:0]   sum;
   assign a   = A_invert ? ~src1 : src1;
   assign b   = B_invert ? ~src2 : src2;
   assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   assign cout = sum[WIDTH];
   always_comb begin
      result = operation == 2'b00 ? a & b :
               operation == 2'b01 ? a | b :
               operation == 2'b10 ? sum[WIDTH-1:0] : {{(WIDTH-1){1'b0}}, less};
   end
endmodule

// File: rtl/alu_func_decode.sv
// alu_func_decode: maps a request function code onto ALU control lines and class flags.
module alu_func_decode
   import alu_pkg::*;
(
   input  logic [2:0] func_i,
   output dec_t       dec_o
);
   logic sub_like, inv_pair;
   assign sub_like = func_i inside {FUNC_SUB, FUNC_SLT, FUNC_SLTU};
   assign inv_pair = func_i inside {FUNC_NOR, FUNC_NAND};
   always_comb begin
      dec_o.a_inv     = inv_pair;
      dec_o.b_inv     = inv_pair | sub_like;
      dec_o.cin       = sub_like;
      dec_o.op        = func_i inside {FUNC_AND, FUNC_NOR} ? ALU_OP_AND :
                        func_i inside {FUNC_OR, FUNC_NAND} ? ALU_OP_OR : ALU_OP_ADD;
      dec_o.is_slt    = func_i inside {FUNC_SLT, FUNC_SLTU};
      dec_o.is_signed = func_i == FUNC_SLT;
      dec_o.is_arith  = func_i inside {FUNC_ADD, FUNC_SUB};
   end
endmodule

// File: rtl/alu32_seq_ctrl.sv
// alu32_seq_ctrl: handshake sequencer driving alu32; SLT/SLTU run as subtract then less-select.
module alu32_seq_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int FUNC_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [FUNC_W-1:0] req_func,
   input  logic [WIDTH-1:0]  req_a,
   input  logic [WIDTH-1:0]  req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WIDTH-1:0]  rsp_data,
   output logic              rsp_zero,
   output logic              rsp_ovf,
   output logic              rsp_cout,
   output logic [WIDTH-1:0]  alu_src1,
   output logic [WIDTH-1:0]  alu_src2,
   output logic              alu_less,
   output logic              alu_a_inv,
   output logic              alu_b_inv,
   output logic              alu_cin,
   output logic [1:0]        alu_op,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic              alu_cout
);
   logic [1:0]        state_q, state_d;
   logic [FUNC_W-1:0] func_q;
   logic [WIDTH-1:0]  data_q;
   logic              zero_q, ovf_q, cout_q, ovf_raw;
   dec_t              dec;
   // Decode the incoming code while idle, the latched one afterwards.
   alu_func_decode u_dec (
      .func_i(state_q == S_IDLE ? req_func : func_q),
      .dec_o (dec)
   );
   assign ovf_raw = (alu_src1[WIDTH-1] ^ alu_result[WIDTH-1]) &
                    ((alu_b_inv ? ~alu_src2[WIDTH-1] : alu_src2[WIDTH-1]) ^ alu_result[WIDTH-1]);
   assign req_ready = state_q == S_IDLE;
   assign rsp_valid = state_q == S_RESP;
   assign rsp_data  = data_q;
   assign rsp_zero  = zero_q;
   assign rsp_ovf   = ovf_q;
   assign rsp_cout  = cout_q;
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = req_valid ? S_EXEC : S_IDLE;
         S_EXEC:  state_d = dec.is_slt ? S_SLT2 : S_RESP;
         S_SLT2:  state_d = S_RESP;
         default: state_d = rsp_ready ? S_IDLE : S_RESP;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         func_q    <= '0;
         data_q    <= '0;
         zero_q    <= 1'b0;
         ovf_q     <= 1'b0;
         cout_q    <= 1'b0;
         alu_src1  <= '0;
         alu_src2  <= '0;
         alu_less  <= 1'b0;
         alu_a_inv <= 1'b0;
         alu_b_inv <= 1'b0;
         alu_cin   <= 1'b0;
         alu_op    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && req_valid) begin
            func_q    <= req_func;
            alu_src1  <= req_a;
            alu_src2  <= req_b;
            alu_less  <= 1'b0;
            alu_a_inv <= dec.a_inv;
            alu_b_inv <= dec.b_inv;
            alu_cin   <= dec.cin;
            alu_op    <= dec.op;
         end
         if (state_q == S_EXEC && dec.is_slt) begin
            // Signed compare uses sign^ovf so it survives subtraction overflow.
            alu_less  <= dec.is_signed ? alu_result[WIDTH-1] ^ ovf_raw : ~alu_cout;
            alu_op    <= ALU_OP_LESS;
            alu_a_inv <= 1'b0;
            alu_b_inv <= 1'b0;
            alu_cin   <= 1'b0;
         end
         if (state_q == S_EXEC && !dec.is_slt) begin
            data_q <= alu_result;
            zero_q <= alu_result == '0;
            ovf_q  <= dec.is_arith & ovf_raw;
            cout_q <= alu_cout;
         end
         if (state_q == S_SLT2) begin
            data_q <= {{(WIDTH-1){1'b0}}, alu_result[0]};
            zero_q <= ~alu_result[0];
            ovf_q  <= 1'b0;
            cout_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu32_seq_ctrl.sv
// tb_alu32_seq_ctrl: directed vector table plus stall and mid-SLT reset sequences.
module tb_alu32_seq_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready;
   logic [2:0]  req_func = '0;
   logic [31:0] req_a = '0, req_b = '0;
   logic        rsp_valid, rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_zero, rsp_ovf, rsp_cout;
   logic [31:0] alu_src1, alu_src2, alu_result;
   logic        alu_less, alu_a_inv, alu_b_inv, alu_cin, alu_cout;
   logic [1:0]  alu_op;
   int checks = 0, errors = 0;

   typedef struct {
      logic [2:0]  func;
      logic [31:0] a, b, data;
      logic        zero, ovf, cout;
      int          lat;
   } vec_t;
   vec_t vecs[16];

   always #5 clk = ~clk;

   alu32_seq_ctrl #(.WIDTH(32), .FUNC_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_cout(rsp_cout),
      .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_less(alu_less),
      .alu_a_inv(alu_a_inv), .alu_b_inv(alu_b_inv), .alu_cin(alu_cin),
      .alu_op(alu_op), .alu_result(alu_result), .alu_cout(alu_cout)
   );

   alu32 #(.WIDTH(32)) u_alu (
      .src1(alu_src1), .src2(alu_src2), .less(alu_less),
      .A_invert(alu_a_inv), .B_invert(alu_b_inv), .cin(alu_cin),
      .operation(alu_op), .result(alu_result), .cout(alu_cout)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_data"}, rsp_data, 32'd0);
      chk({tag, "_rsp_flags"}, {29'd0, rsp_zero, rsp_ovf, rsp_cout}, 32'd0);
      chk({tag, "_alu_src"}, alu_src1 | alu_src2, 32'd0);
      chk({tag, "_alu_ctl"}, {26'd0, alu_less, alu_a_inv, alu_b_inv, alu_cin, alu_op}, 32'd0);
   endtask

   task automatic do_req(input int idx, input vec_t v);
      int w, lat;
      @(negedge clk);
      req_valid = 1'b1; req_func = v.func; req_a = v.a; req_b = v.b;
      w = 0;
      while (!req_ready && w < 20) begin @(negedge clk); w++; end
      chk($sformatf("v%0d_accept", idx), 32'(w < 20), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
      chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
      chk($sformatf("v%0d_data", idx), rsp_data, v.data);
      chk($sformatf("v%0d_flags_zov_cout", idx), {29'd0, rsp_zero, rsp_ovf, rsp_cout},
          {29'd0, v.zero, v.ovf, v.cout});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk($sformatf("v%0d_back_idle", idx), {30'd0, req_ready, rsp_valid}, 32'b10);
   endtask

   initial begin
      vecs[0]  = '{3'd2, 32'h00000005, 32'h00000003, 32'h00000008, 0, 0, 0, 2};
      vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1, 2};
      vecs[2]  = '{3'd3, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 1, 2};
      vecs[3]  = '{3'd3, 32'h00000007, 32'h00000007, 32'h00000000, 1, 0, 1, 2};
      vecs[4]  = '{3'd4, 32'h80000000, 32'h00000001, 32'h00000001, 0, 0, 0, 3};
      vecs[5]  = '{3'd5, 32'h80000000, 32'h00000001, 32'h00000000, 1, 0, 0, 3};
      vecs[6]  = '{3'd6, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 1, 0, 0, 2};
      vecs[7]  = '{3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0, 2};
      vecs[8]  = '{3'd0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 0, 0, 1, 2};
      vecs[9]  = '{3'd1, 32'h12340000, 32'h00005678, 32'h12345678, 0, 0, 0, 2};
      vecs[10] = '{3'd4, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1, 0, 0, 3};
      vecs[11] = '{3'd4, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 3};
      vecs[12] = '{3'd5, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 3};
      vecs[13] = '{3'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0, 2};
      vecs[14] = '{3'd5, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0, 0, 3};
      vecs[15] = '{3'd4, 32'h00000003, 32'hFFFFFFFE, 32'h00000000, 1, 0, 0, 3};

      #12;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) do_req(i, vecs[i]);

      // Response stall with a second request waiting
      begin
         int lat;
         @(negedge clk);
         req_valid = 1'b1; req_func = 3'd2; req_a = 32'd1; req_b = 32'd2;
         @(posedge clk);
         @(negedge clk);
         req_func = 3'd1; req_a = 32'h00F0; req_b = 32'h0F00;
         lat = 1;
         while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
         chk("stall_first_latency", 32'(lat), 32'd2);
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall_hold%0d", c),
                {rsp_valid, req_ready, rsp_zero, rsp_ovf, rsp_cout, rsp_data[26:0]},
                {1'b1, 1'b0, 3'b000, 27'd3});
         end
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         chk("stall_idle_after_hs", {30'd0, req_ready, rsp_valid}, 32'b10);
         @(posedge clk);
         @(negedge clk);
         req_valid = 1'b0;
         lat = 1;
         while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
         chk("stall_second_latency", 32'(lat), 32'd2);
         chk("stall_second_data", rsp_data, 32'h0FF0);
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
      end

      // Reset while the SLT select pass is in progress
      @(negedge clk);
      req_valid = 1'b1; req_func = 3'd4; req_a = 32'h80000000; req_b = 32'd1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("slt_in_exec_op", 32'(alu_op), 32'b10);
      @(negedge clk);
      chk("slt_in_slt2_ctl", {29'd0, alu_op, alu_less}, 32'b111);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("midrst_no_rsp%0d", c), 32'(rsp_valid), 32'd0);
      end
      do_req(99, vecs[11]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu32_seq_ctrl.md
Name: alu32_seq_ctrl

Overview:
- Sequencing controller that owns the control side of the 32-bit ALU datapath (alu32).
- Accepts operation requests over a valid/ready handshake and drives the ALU's operand and control lines: src1, src2, less, A_invert, B_invert, cin, operation.
- Captures the ALU result and returns it with status flags over a second valid/ready handshake.
- Set-less-than is executed as a two-pass subtract-then-select sequence.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU width.
- FUNC_W, 3, width of the request function code.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request presented.
- req_ready  output  1  controller can accept a request.
- req_func  input  FUNC_W  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT (signed), 5 SLTU, 6 NOR, 7 NAND.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- rsp_valid  output  1  response held valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  WIDTH  result.
- rsp_zero  output  1  rsp_data == 0.
- rsp_ovf  output  1  signed overflow (ADD/SUB only, else 0).
- rsp_cout  output  1  ALU carry out of the final pass.
- alu_src1, alu_src2  output  WIDTH  to ALU src1/src2.
- alu_less, alu_a_inv, alu_b_inv, alu_cin  output  1  to ALU.
- alu_op  output  2  to ALU operation (00 AND, 01 OR, 10 ADD, 11 LESS).
- alu_result  input  WIDTH  from ALU.
- alu_cout  input  1  from ALU.

Behaviour:
- Reset: state IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_zero=0; rsp_ovf=0; rsp_cout=0. All alu_* outputs are 0. Reset mid-operation discards the request in flight; no response is produced for it.
- The ALU is combinational. alu_* outputs are registered from the operand/control latches. alu_result is sampled on the clock edge ending each EXEC or SLT2 cycle.
- FSM states: IDLE, EXEC, SLT2, RESP.
  - IDLE: req_ready=1. On req_valid, latch func, a, b and go to EXEC. req_ready=0 in every state other than IDLE.
  - EXEC: drive the ALU according to the mapping below.
    - Non-SLT functions: capture result and flags, then go to RESP.
    - SLT/SLTU: compute set = (r[31]^ovf) for SLT, set = ~alu_cout for SLTU, then go to SLT2.
  - SLT2: drive alu_op=11, alu_less=set, alu_a_inv=0, alu_b_inv=0, alu_cin=0. Capture rsp_data = {WIDTH-1 zeros, alu_result[0]}, rsp_ovf=0, rsp_cout=0. Go to RESP.
  - RESP: rsp_valid=1. Outputs stay stable until rsp_ready. On rsp_ready go to IDLE; no back-to-back bypass.
- Function mapping, as {a_inv, b_inv, cin, op}:
  - AND 0,0,0,00.
  - OR 0,0,0,01.
  - ADD 0,0,0,10.
  - SUB 0,1,1,10.
  - SLT/SLTU pass 1: 0,1,1,10.
  - NOR 1,1,0,00.
  - NAND 1,1,0,01.
- Flags:
  - ovf = (a[31]^r[31]) & (beff[31]^r[31]), where beff = b_inv ? ~b : b. Only ADD/SUB report ovf.
  - zero is computed from the captured rsp_data.
- Latency: accept handshake in cycle N. rsp_valid asserts in cycle N+2 for single-pass functions and N+3 for SLT/SLTU.
- Throughput: one request per 3 (or 4) cycles plus the response stall.
- Boundaries:
  - ADD 0xFFFFFFFF+1 gives result 0, cout=1, zero=1, ovf=0.
  - SUB 0x80000000-1 gives ovf=1.
  - SLT uses sign^ovf, so it is correct across overflow.
  - Undefined func codes cannot occur (3-bit fully decoded).

Decomposition:
- Shared package alu_pkg holds:
  - FUNC_* localparams for the request codes.
  - ALU_OP_AND/OR/ADD/LESS encodings.
  - State encoding constants.
- One natural sub-module: alu_func_decode. It is combinational, mapping func to {a_inv, b_inv, cin, op, is_slt, is_signed, is_arith}, and is reusable by future decoders.
- The bench instantiates alu32 next to the controller, wiring alu_* ports directly.

Test Plan:
- ADD a=0x00000005 b=0x00000003 -> rsp_data=0x00000008, zero=0, ovf=0, cout=0, rsp_valid at accept+2.
- SUB a=0x80000000 b=0x00000001 -> rsp_data=0x7FFFFFFF, ovf=1; SUB a=7 b=7 -> data=0, zero=1, cout=1.
- SLT a=0x80000000 (neg) b=1 -> data=1. SLTU with the same operands -> data=0. Both give rsp_valid at accept+3.
- NOR a=0x0F0F0F0F b=0xF0F0F0F0 -> data=0, zero=1; NAND a=b=0xFFFFFFFF -> data=0.
- Hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_* stable, req_ready=0, second request accepted only after the RESP handshake.
- Assert rst_n=0 during SLT2 -> all outputs return to reset values immediately; next request completes normally.
